// File: rtl/gpio_processing_delay_max_multi.sv
// rtl/gpio_processing_delay_max_multi.sv - AXI4-Lite multi-channel processing-delay-max bank
// Each channel has a software shadow and an active limit; COMMIT moves shadows to active in one clock.
module gpio_processing_delay_max_multi #(
  parameter int              NUM_CHANNELS         = 4,
  parameter int              TIMESTAMP_WIDTH      = 72,
  parameter longint unsigned PROCESSING_DELAY_MAX = 50000000,
  parameter int              C_S_AXI_DATA_WIDTH   = 32,
  parameter int              C_S_AXI_ADDR_WIDTH   = $clog2(16 + 16 * NUM_CHANNELS)
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]           S_AXI_AWADDR,
  input  logic [2:0]                              S_AXI_AWPROT,
  input  logic                                    S_AXI_AWVALID,
  output logic                                    S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]           S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]         S_AXI_WSTRB,
  input  logic                                    S_AXI_WVALID,
  output logic                                    S_AXI_WREADY,
  output logic [1:0]                              S_AXI_BRESP,
  output logic                                    S_AXI_BVALID,
  input  logic                                    S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]           S_AXI_ARADDR,
  input  logic [2:0]                              S_AXI_ARPROT,
  input  logic                                    S_AXI_ARVALID,
  output logic                                    S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]           S_AXI_RDATA,
  output logic [1:0]                              S_AXI_RRESP,
  output logic                                    S_AXI_RVALID,
  input  logic                                    S_AXI_RREADY,
  output logic [NUM_CHANNELS*TIMESTAMP_WIDTH-1:0] processing_delay_max,
  output logic [NUM_CHANNELS-1:0]                 update_pulse
);

  localparam int TW      = TIMESTAMP_WIDTH;
  localparam int NC      = NUM_CHANNELS;
  localparam int WORDS   = (TW + 31) / 32;
  localparam int PW      = WORDS * 32;
  localparam int CW      = (NC > 1) ? $clog2(NC) : 1;
  localparam int MAP_END = 16 + 16 * NC;
  localparam logic [TW-1:0] RST_VAL = TW'(PROCESSING_DELAY_MAX);

  typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_RESP} rstate_t;

  wstate_t wstate_q, wstate_d;
  rstate_t rstate_q, rstate_d;

  logic [TW-1:0]   shadow [NC];
  logic [TW-1:0]   active [NC];
  logic [NC-1:0]   pending;
  logic [31:0]     commit_count;
  logic [1:0]      bresp;
  logic [31:0]     rdata;
  logic [1:0]      rresp;

  // Write-side address decode
  logic [31:0]     w_addr, w_word, wdata_masked;
  logic            w_map, w_commit, w_shadow;
  logic [CW-1:0]   w_ch;
  logic [NC-1:0]   commit_mask;
  logic [PW-1:0]   sh_pad;
  logic [TW-1:0]   sh_new;

  assign w_addr   = 32'(S_AXI_AWADDR);
  assign w_word   = {30'd0, w_addr[3:2]};
  assign w_map    = w_addr < 32'(MAP_END);
  assign w_commit = w_addr[31:2] == 30'd0;
  assign w_shadow = w_map && (w_addr >= 32'd16) && (w_word < WORDS);
  assign w_ch     = CW'(w_addr[31:4] - 28'd1);

  always_comb begin
    wdata_masked = '0;
    for (int b = 0; b < 4; b++)
      if (S_AXI_WSTRB[b]) wdata_masked[b*8 +: 8] = S_AXI_WDATA[b*8 +: 8];
  end
  assign commit_mask = wdata_masked[NC-1:0];

  // Byte-merge into a word-padded copy so bits past TW fall off on truncation
  always_comb begin
    sh_pad = PW'(shadow[w_ch]);
    for (int w = 0; w < WORDS; w++)
      for (int b = 0; b < 4; b++)
        if (w_word == 32'(w) && S_AXI_WSTRB[b])
          sh_pad[w*32 + b*8 +: 8] = S_AXI_WDATA[b*8 +: 8];
    sh_new = sh_pad[TW-1:0];
  end

  // Read-side address decode
  logic [31:0]     r_addr, r_word, rd_data;
  logic            r_map, r_chan, rd_err;
  logic [CW-1:0]   r_ch;
  logic [PW-1:0]   rd_pad;

  assign r_addr = 32'(S_AXI_ARADDR);
  assign r_word = {30'd0, r_addr[3:2]};
  assign r_map  = r_addr < 32'(MAP_END);
  assign r_chan = r_map && (r_addr >= 32'd16);
  assign r_ch   = CW'(r_addr[31:4] - 28'd1);

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    rd_pad  = PW'(shadow[r_ch]);
    if (!r_map) begin
      rd_err = 1'b1;
    end else if (r_addr[31:2] == 30'd0) begin
      rd_data = 32'(pending);
    end else if (r_addr[31:2] == 30'd1) begin
      rd_data = commit_count;
    end else if (r_chan) begin
      if (r_word == 32'd3) begin
        rd_data = 32'(active[r_ch]);
      end else begin
        for (int w = 0; w < WORDS; w++)
          if (r_word == 32'(w)) rd_data = rd_pad[w*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
    end
  end

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE:   if (S_AXI_AWVALID && S_AXI_WVALID) wstate_d = W_ACCEPT;
      W_ACCEPT: wstate_d = W_RESP;
      W_RESP:   if (S_AXI_BREADY) wstate_d = W_IDLE;
      default:  wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:   if (S_AXI_ARVALID) rstate_d = R_ACCEPT;
      R_ACCEPT: rstate_d = R_RESP;
      R_RESP:   if (S_AXI_RREADY) rstate_d = R_IDLE;
      default:  rstate_d = R_IDLE;
    endcase
  end

  // Register updates land on the handshake edge that leaves ACCEPT
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < NC; c++) begin
        shadow[c] <= RST_VAL;
        active[c] <= RST_VAL;
      end
      pending      <= '0;
      commit_count <= '0;
      update_pulse <= '0;
      bresp        <= 2'b00;
    end else begin
      update_pulse <= '0;
      if (wstate_q == W_ACCEPT) begin
        bresp <= w_map ? 2'b00 : 2'b10;
        if (w_commit) begin
          for (int c = 0; c < NC; c++)
            if (commit_mask[c]) active[c] <= shadow[c];
          pending      <= pending & ~commit_mask;
          update_pulse <= commit_mask;
          if (|commit_mask) commit_count <= commit_count + 32'd1;
        end else if (w_shadow) begin
          shadow[w_ch]  <= sh_new;
          pending[w_ch] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
      rresp <= 2'b00;
    end else if (rstate_q == R_ACCEPT) begin
      rdata <= rd_data;
      rresp <= rd_err ? 2'b10 : 2'b00;
    end
  end

  assign S_AXI_AWREADY = (wstate_q == W_ACCEPT);
  assign S_AXI_WREADY  = (wstate_q == W_ACCEPT);
  assign S_AXI_BVALID  = (wstate_q == W_RESP);
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_ARREADY = (rstate_q == R_ACCEPT);
  assign S_AXI_RVALID  = (rstate_q == R_RESP);
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = rresp;

  genvar gc;
  generate
    for (gc = 0; gc < NC; gc++) begin : g_out
      assign processing_delay_max[gc*TW +: TW] = active[gc];
    end
  endgenerate

  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, w_addr[1:0], r_addr[1:0],
                    wdata_masked, sh_pad, rd_pad};

endmodule

// File: tb/tb_gpio_processing_delay_max_multi.sv
// tb/tb_gpio_processing_delay_max_multi.sv - self-checking bench for gpio_processing_delay_max_multi
module tb_gpio_processing_delay_max_multi;
  localparam int NC = 4;
  localparam int TW = 72;
  localparam int WORDS = 3;
  localparam int AW = 7;
  localparam logic [TW-1:0] DEF = 72'd50000000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]    awaddr = '0, araddr = '0;
  logic [2:0]       awprot = '0, arprot = '0;
  logic             awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic             awready, wready, bvalid, arready, rvalid;
  logic [31:0]      wdata = '0, rdata;
  logic [3:0]       wstrb = '0;
  logic [1:0]       bresp, rresp;
  logic [NC*TW-1:0] pdm;
  logic [NC-1:0]    update_pulse;

  gpio_processing_delay_max_multi dut (
    .clk(clk), .rstn(rstn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .processing_delay_max(pdm), .update_pulse(update_pulse)
  );

  int checks = 0;
  int errors = 0;

  logic [TW-1:0] msh [NC];
  logic [TW-1:0] mact [NC];
  logic [NC-1:0] mpend;
  logic [31:0]   mcnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      msh[c]  = DEF;
      mact[c] = DEF;
    end
    mpend = '0;
    mcnt  = '0;
  endtask

  task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [NC-1:0] pulse);
    int c, w;
    logic [31:0] m;
    pulse = '0;
    resp  = 2'b00;
    if (a >= 16 + 16 * NC) begin
      resp = 2'b10;
    end else if (a < 4) begin
      m = '0;
      for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
      pulse = m[NC-1:0];
      for (int k = 0; k < NC; k++)
        if (pulse[k]) begin
          mact[k]  = msh[k];
          mpend[k] = 1'b0;
        end
      if (pulse != 0) mcnt = mcnt + 32'd1;
    end else if (a >= 16) begin
      c = (a - 16) / 16;
      w = (a % 16) / 4;
      if (w < WORDS) begin
        for (int i = 0; i < 32; i++)
          if (s[i/8] && (32 * w + i) < TW) msh[c][32*w+i] = d[i];
        mpend[c] = 1'b1;
      end
    end
  endtask

  task automatic model_read(input int a, output logic [31:0] d, output logic [1:0] r);
    int c, w;
    logic [TW-1:0] t;
    d = '0;
    r = 2'b00;
    if (a >= 16 + 16 * NC) begin
      r = 2'b10;
    end else if (a < 16) begin
      if (a / 4 == 0) d = 32'(mpend);
      else if (a / 4 == 1) d = mcnt;
    end else begin
      c = (a - 16) / 16;
      w = (a % 16) / 4;
      if (w == 3) d = mact[c][31:0];
      else if (w < WORDS) begin
        t = msh[c] >> (32 * w);
        d = t[31:0];
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int c = 0; c < NC; c++) chk(tag, pdm[c*TW +: TW], mact[c]);
  endtask

  task automatic axi_write(input int a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] eresp;
    logic [NC-1:0] epulse;
    int n;
    model_write(a, d, s, eresp, epulse);
    @(negedge clk);
    awaddr = AW'(a); wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    n = 0;
    while (awready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("aw_latency", n, 1);
    chk("wready", wready, 1);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, eresp);
    chk("update_pulse", update_pulse, epulse);
    check_outputs("outputs_after_write");
    bready = 1;
    @(negedge clk);
    bready = 0;
    chk("bvalid_clear", bvalid, 0);
    chk("pulse_clear", update_pulse, 0);
  endtask

  task automatic axi_read(input int a, input int hold);
    logic [31:0] ed;
    logic [1:0] er;
    int n;
    model_read(a, ed, er);
    @(negedge clk);
    araddr = AW'(a); arvalid = 1;
    n = 0;
    while (arready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("ar_latency", n, 1);
    @(negedge clk);
    arvalid = 0;
    for (int h = 0; h <= hold; h++) begin
      chk("rvalid", rvalid, 1);
      chk("rdata", rdata, ed);
      chk("rresp", rresp, er);
      if (h < hold) @(negedge clk);
    end
    rready = 1;
    @(negedge clk);
    rready = 0;
    chk("rvalid_clear", rvalid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, c, w;
    logic [31:0] d;

    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_bvalid", bvalid, 0);
    chk("reset_rvalid", rvalid, 0);
    chk("reset_awready", awready, 0);
    chk("reset_arready", arready, 0);
    chk("reset_pulse", update_pulse, 0);
    chk("reset_rdata", rdata, 0);
    rstn = 1;
    check_outputs("reset_outputs");
    chk("reset_ch0_literal", pdm[0 +: TW], 72'd50000000);
    for (int a = 0; a < 16 + 16 * NC; a += 4) axi_read(a, 0);

    // Tear-free multi-word update of channel 1
    axi_write(32'h20, 32'h11111111, 4'hF);
    axi_write(32'h24, 32'h22222222, 4'hF);
    axi_write(32'h28, 32'h00000033, 4'hF);
    chk("ch1_unchanged", pdm[1*TW +: TW], DEF);
    axi_read(32'h00, 0);
    axi_write(32'h00, 32'h2, 4'hF);
    chk("ch1_committed", pdm[1*TW +: TW], 72'h33_22222222_11111111);
    axi_read(32'h00, 0);
    axi_read(32'h04, 0);
    axi_read(32'h2C, 0);

    // Multi-channel commit and masked-off commit
    axi_write(32'h10, 32'hDEADBEEF, 4'hF);
    axi_write(32'h48, 32'h000000A5, 4'h1);
    axi_write(32'h00, 32'h0000000F, 4'h1);
    axi_write(32'h00, 32'h00000100, 4'hF);
    axi_read(32'h04, 0);

    // Byte strobes and truncation above TW
    axi_write(32'h38, 32'hAABBCCDD, 4'h5);
    axi_read(32'h38, 2);
    chk("ch2_word2_model", msh[2][71:64], 8'hDD);

    // Error responses and read backpressure
    axi_read(32'h50, 10);
    axi_write(32'h50, 32'hFFFFFFFF, 4'hF);
    axi_write(32'h7C, 32'h0000000F, 4'hF);
    axi_read(32'h14, 5);
    axi_write(32'h0C, 32'h12345678, 4'hF);
    axi_write(32'h1C, 32'h12345678, 4'hF);
    axi_read(32'h1C, 0);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 9);
      c  = $urandom_range(0, NC - 1);
      w  = $urandom_range(0, 3);
      d  = $urandom;
      if (op <= 4) axi_write(16 + 16 * c + 4 * w, d, 4'($urandom_range(0, 15)));
      else if (op <= 6) axi_write(0, d, 4'($urandom_range(0, 15)));
      else if (op == 7) axi_write(4 * $urandom_range(0, 31), d, 4'($urandom_range(0, 15)));
      else axi_read(4 * $urandom_range(0, 31), $urandom_range(0, 3));
    end

    // Commit counter wrap
    @(negedge clk);
    force dut.commit_count = 32'hFFFFFFFF;
    #1;
    release dut.commit_count;
    mcnt = 32'hFFFFFFFF;
    axi_read(32'h04, 0);
    axi_write(32'h00, 32'h1, 4'h1);
    axi_read(32'h04, 0);
    chk("count_wrapped_model", mcnt, 0);

    // Reset while a write response is pending
    axi_write(32'h10, 32'h0BADF00D, 4'hF);
    @(negedge clk);
    awaddr = AW'(32'h00); wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    chk("midb_bvalid", bvalid, 1);
    rstn = 0;
    #1;
    model_reset();
    chk("midb_bvalid_drop", bvalid, 0);
    chk("midb_pulse", update_pulse, 0);
    check_outputs("midb_outputs");
    @(negedge clk);
    rstn = 1;
    axi_read(32'h10, 0);
    axi_read(32'h00, 0);
    axi_read(32'h04, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpio_processing_delay_max_multi.md
# gpio_processing_delay_max_multi

Multi-channel, AXI4-Lite-programmable processing-delay-max register bank for the ATS path. Each channel holds a TIMESTAMP_WIDTH-bit limit as a software-writable shadow plus an active copy; a single COMMIT write transfers any set of shadows to their active copies in one clock. This removes tearing on wide values that span several 32-bit writes. Active values drive the per-port eligibility/transmission logic; the block contains its own AXI4-Lite slave.

## Interface
- NUM_CHANNELS, 4, number of independent delay limits (1..16)
- TIMESTAMP_WIDTH, 72, width of each limit (1..96); WORDS = ceil(TIMESTAMP_WIDTH/32)
- PROCESSING_DELAY_MAX, 50000000, reset value of every shadow and active limit, zero-extended/truncated to TIMESTAMP_WIDTH
- C_S_AXI_DATA_WIDTH, 32, AXI data width (fixed 32)
- C_S_AXI_ADDR_WIDTH, $clog2(16+16*NUM_CHANNELS), byte address width

Ports:
- clk  in  1  single clock for all logic
- rstn  in  1  reset, asynchronous, active-low
- S_AXI_AW*/W*/B*/AR*/R*  standard AXI4-Lite slave channels, 32-bit data, C_S_AXI_ADDR_WIDTH address; AWPROT/ARPROT ignored
- processing_delay_max  out  NUM_CHANNELS*TIMESTAMP_WIDTH  active limits, channel c at [c*TIMESTAMP_WIDTH +: TIMESTAMP_WIDTH]
- update_pulse  out  NUM_CHANNELS  one-cycle strobe per channel when its active value is loaded

## Operation
- Register map (byte offsets):
  - 0x00 COMMIT: write bit c = 1 (lane strobe set) commits channel c; read returns pending mask
  - 0x04 COMMIT_COUNT: read-only; increments by 1 per COMMIT write with nonzero effective mask; wraps 0xFFFFFFFF->0
  - 0x08, 0x0C: reserved, read 0, writes OKAY and ignored
  - 0x10+0x10*c + 4*w, w<WORDS: shadow word w of channel c (bits [32w+31:32w]); bits above TIMESTAMP_WIDTH read 0 and are not stored
  - 0x10+0x10*c + 4*w, WORDS<=w<3: read 0, writes ignored, OKAY
  - 0x10+0x10*c + 0xC: read-only, active[31:0] of channel c
  - any offset >= 0x10+0x10*NUM_CHANNELS: unmapped, BRESP/RRESP = SLVERR (2'b10), RDATA 0, no state change
- Shadow writes honour WSTRB per byte; sets pending[c].
- COMMIT: effective mask = WDATA masked by WSTRB lanes, bits >= NUM_CHANNELS dropped. For each set bit: active <= shadow, pending[c] <= 0, update_pulse[c] = 1. Channels already non-pending still copy and pulse.
- Active values change only on COMMIT; writes to shadow never alter processing_delay_max.
- Write FSM: IDLE -> ACCEPT (AWREADY=WREADY=1 one cycle) -> RESP (BVALID held until BREADY) -> IDLE. AW and W are accepted only together.
- Read FSM: IDLE -> ACCEPT (ARREADY=1 one cycle, RDATA captured) -> RESP (RVALID held until RREADY) -> IDLE. Independent of write FSM.

## Timing
- Reset (async, immediate): all shadow and active = PROCESSING_DELAY_MAX, pending=0, COMMIT_COUNT=0, update_pulse=0, AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0. Reset mid-transaction drops BVALID/RVALID; the transaction is lost.
- Write: AWVALID&WVALID sampled high in IDLE at cycle N -> AWREADY=WREADY=1 at N+1 -> register/active update, update_pulse and BVALID visible at N+2.
- Back-to-back: next write accepted no earlier than the cycle after B handshake.
- Read: ARVALID in IDLE at N -> ARREADY at N+1 -> RVALID with data at N+2; data reflects state at N+1 (a write landing at N+2 is not seen).
- RDATA/RRESP stable while RVALID=1 and RREADY=0; BRESP stable while BVALID=1.
- update_pulse high exactly one cycle per commit; multiple channels pulse in the same cycle.

## Test plan
- Reset: NUM_CHANNELS=4, TIMESTAMP_WIDTH=72 -> every channel reads 50000000 at word0, 0 at words 1-2, pending 0, COUNT 0, outputs 72'd50000000.
- Tear-free update: write ch1 words 0x11111111, 0x22222222, 0x33 -> output unchanged, pending=0x2. COMMIT 0x2 -> at N+2 ch1 = 72'h33_22222222_11111111, update_pulse=0b0010, pending 0, COUNT 1.
- Multi-commit: shadows written on ch0 and ch3; COMMIT 0xF with WSTRB=0x1 -> all four pulse same cycle; COMMIT 0x100 -> mask 0, COUNT unchanged.
- Strobes/width: write 0xAABBCCDD WSTRB=0x5 to ch2 word2 -> stored 0x..BB..DD truncated to 8 bits: reads 0xDD.
- Errors/backpressure: read 0x50 -> RRESP SLVERR, RDATA 0; hold RREADY low 10 cycles -> RVALID/RDATA stable; write unmapped -> SLVERR, no change.
- COUNT wrap and reset mid-B: force 2^32 commits (or preload by force) -> 0; assert rstn low while BVALID=1 -> BVALID 0 at once, values back to default.
